// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag stage.
//   cond_e       : the sixteen instruction condition encodings (EQ..AL, NV).
//   FLAG_N..V    : bit positions inside a packed {N,Z,C,V} flag word.  The ALU
//                  packs its flag outputs with the same indices.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator.
// Ports:
//   cond_i    [3:0] : instruction condition field
//   flags_i   [3:0] : flag word {N,Z,C,V}
//   cond_ex_o       : condition passes
//   illegal_o       : reserved encoding 4'b1111 seen
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o,
  output logic       illegal_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    illegal_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: illegal_o = 1'b1;
      default: begin
        cond_ex_o = 1'b0;
        illegal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition/flag stage downstream of the ALU.
// Holds the architectural NZCV register, evaluates the instruction condition
// against the registered flags, and gates the decoder write strobes so an
// instruction whose condition fails has no side effects.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   Cond        [3:0]   : condition field of current instruction
//   ALUFlags    [3:0]   : ALU {N,Z,C,V} this cycle
//   FlagW       [1:0]   : [1] writes N,Z ; [0] writes C,V
//   PCS, RegW, MemW     : ungated decoder write strobes
//   NoWrite             : compare-type op, suppresses RegWrite
//   stall               : freeze the flag register
//   PCSrc, RegWrite, MemWrite : gated strobes
//   CondEx              : condition passed (combinational)
//   Flags       [3:0]   : registered {N,Z,C,V}
//   IllegalCond         : reserved condition 4'b1111 this cycle
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       IllegalCond
);

  // N,Z and C,V are separate registers so logical ops can update N,Z while
  // leaving the arithmetic carry/overflow untouched.
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       flag_upd;

  assign Flags = {nz_q, cv_q};

  // Decode uses the registered flags only; an instruction never sees the
  // flags it is producing itself.
  cond_check u_cond_check (
    .cond_i    (Cond),
    .flags_i   (Flags),
    .cond_ex_o (CondEx),
    .illegal_o (IllegalCond)
  );

  assign flag_upd = ~stall & CondEx;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (flag_upd) begin
      if (FlagW[1]) nz_d = ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) cv_d = ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= RESET_FLAGS[FLAG_N:FLAG_Z];
      cv_q <= RESET_FLAGS[FLAG_C:FLAG_V];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

endmodule
